// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Owns the PC, selects the next PC, drives the
// instruction-memory request/ready handshake, and presents
// {PC+4, instruction, valid} to the IF/ID register every cycle.
// A word returned while the pipeline is stalled is parked in inst_buf.
//
// Ports:
//   clk            clock, all state updates on posedge
//   reset          asynchronous, active-low reset
//   PCWrite        1 = PC may advance, 0 = stall
//   PCSrc[2:0]     next-PC select (0 PC+4, 1 branch, 2 jump, 3 jr,
//                  4 interrupt, 5 exception, 6/7 as 0)
//   branch_target  branch destination
//   jump_target    J/JAL instr_index field
//   jr_target      register-jump destination
//   imem_req       fetch request
//   imem_addr      fetch address (= PC)
//   imem_rdata     fetched word, valid with imem_ready
//   imem_ready     memory returns imem_rdata this cycle
//   PC_plus4       PC+4 of the current fetch
//   instruction    fetched instruction to IF/ID
//   IF_Flush       1 = instruction valid, 0 = bubble
//   fetch_stall    1 while waiting on imem_ready
//   PC_current     current PC (EPC capture)
//   addr_err       one-cycle pulse on a taken, misaligned jr
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR   = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic [2:0]  PCSrc,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_target,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC_plus4,
    output logic [31:0] instruction,
    output logic        IF_Flush,
    output logic        fetch_stall,
    output logic [31:0] PC_current,
    output logic        addr_err
);

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] inst_buf_r;
    logic [31:0] inst_buf_nxt_s;

    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;
    logic        jr_misalign_s;
    logic        redirect_s;
    logic        req_s;
    logic        stall_s;
    logic        flush_s;
    logic [31:0] instr_s;

    assign pc_plus4_s = pc_r + 32'd4;
    assign imem_addr  = pc_r;
    assign PC_current = pc_r;
    assign PC_plus4   = pc_plus4_s;

    // Interrupt/exception redirects ignore PCWrite; branch/jump/jr need it.
    assign redirect_s = (PCSrc == 3'd4) || (PCSrc == 3'd5) ||
                        (PCWrite && (PCSrc >= 3'd1) && (PCSrc <= 3'd3));

    // Next-PC selection; a misaligned jr is diverted to the exception vector.
    always_comb begin
        next_pc_s     = pc_plus4_s;
        jr_misalign_s = 1'b0;
        case (PCSrc)
            3'd1: next_pc_s = branch_target;
            3'd2: next_pc_s = {pc_plus4_s[31:28], jump_target, 2'b00};
            3'd3: begin
                if (jr_target[1:0] != 2'b00) begin
                    next_pc_s     = EXC_VECTOR;
                    jr_misalign_s = 1'b1;
                end else begin
                    next_pc_s     = jr_target;
                end
            end
            3'd4:    next_pc_s = INT_VECTOR;
            3'd5:    next_pc_s = EXC_VECTOR;
            default: next_pc_s = pc_plus4_s;
        endcase
    end

    // Fetch FSM: next state, PC/buffer update and raw handshake outputs.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        inst_buf_nxt_s = inst_buf_r;
        req_s          = 1'b0;
        stall_s        = 1'b0;
        flush_s        = 1'b0;
        instr_s        = 32'd0;
        case (state_r)
            ST_REQ: begin
                req_s = 1'b1;
                if (!imem_ready) begin
                    // Pending fetch; a redirect simply retargets it.
                    stall_s = 1'b1;
                    if (redirect_s) begin
                        pc_nxt_s = next_pc_s;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end else begin
                    instr_s = imem_rdata;
                    if (redirect_s) begin
                        pc_nxt_s = next_pc_s;
                    end else if (PCWrite) begin
                        flush_s  = 1'b1;
                        pc_nxt_s = pc_plus4_s;
                    end else begin
                        // Pipeline stalled: park the word until release.
                        flush_s        = 1'b1;
                        inst_buf_nxt_s = imem_rdata;
                        state_nxt_s    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                instr_s = inst_buf_r;
                if (redirect_s) begin
                    pc_nxt_s       = next_pc_s;
                    inst_buf_nxt_s = 32'd0;
                    state_nxt_s    = ST_REQ;
                end else if (PCWrite) begin
                    flush_s     = 1'b1;
                    pc_nxt_s    = pc_plus4_s;
                    state_nxt_s = ST_REQ;
                end else begin
                    flush_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_REQ;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    always_comb begin
        if (!reset) begin
            imem_req    = 1'b0;
            instruction = 32'd0;
            IF_Flush    = 1'b0;
            fetch_stall = 1'b0;
            addr_err    = 1'b0;
        end else begin
            imem_req    = req_s;
            instruction = instr_s;
            IF_Flush    = flush_s;
            fetch_stall = stall_s;
            addr_err    = jr_misalign_s && PCWrite;
        end
    end

    // State, PC and instruction buffer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_REQ;
            pc_r       <= RESET_VECTOR;
            inst_buf_r <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            inst_buf_r <= inst_buf_nxt_s;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed test-plan steps followed by random stimulus, each cycle checked
// against a small behavioural model of the fetch stage (PC, "word parked"
// flag and parked word).
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] IV  = 32'h8000_0004;
    localparam logic [31:0] EV  = 32'h8000_0008;

    logic        clk;
    logic        reset;
    logic        PCWrite;
    logic [2:0]  PCSrc;
    logic [31:0] branch_target;
    logic [25:0] jump_target;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] PC_plus4;
    logic [31:0] instruction;
    logic        IF_Flush;
    logic        fetch_stall;
    logic [31:0] PC_current;
    logic        addr_err;

    int n_tests;
    int n_fail;

    // Model state
    logic [31:0] m_pc;
    logic        m_parked;
    logic [31:0] m_word;

    if_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .PC_plus4      (PC_plus4),
        .instruction   (instruction),
        .IF_Flush      (IF_Flush),
        .fetch_stall   (fetch_stall),
        .PC_current    (PC_current),
        .addr_err      (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called at a negedge, drives inputs, checks, advances model.
    task automatic step(input logic pcw, input logic [2:0] src, input logic [31:0] bt,
                        input logic [25:0] jt, input logic [31:0] jrt,
                        input logic rdy, input logic [31:0] rd);
        logic [31:0] p4;
        logic [31:0] target;
        logic        taken;
        logic        misalign;
        PCWrite       = pcw;
        PCSrc         = src;
        branch_target = bt;
        jump_target   = jt;
        jr_target     = jrt;
        imem_ready    = rdy;
        imem_rdata    = rd;
        #1;
        p4       = m_pc + 32'd4;
        misalign = (jrt[1:0] != 2'b00);
        if (src == 3'd1)      target = bt;
        else if (src == 3'd2) target = {p4[31:28], jt, 2'b00};
        else if (src == 3'd3) target = misalign ? EV : jrt;
        else if (src == 3'd4) target = IV;
        else if (src == 3'd5) target = EV;
        else                  target = p4;
        taken = (src == 3'd4) || (src == 3'd5) || (pcw && src >= 3'd1 && src <= 3'd3);

        chk("imem_addr",  imem_addr,  m_pc);
        chk("PC_current", PC_current, m_pc);
        chk("PC_plus4",   PC_plus4,   p4);
        chk("addr_err",   {31'd0, addr_err}, {31'd0, pcw && src == 3'd3 && misalign});
        if (!m_parked) begin
            chk("imem_req",    {31'd0, imem_req},    32'd1);
            chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, !rdy});
            chk("IF_Flush",    {31'd0, IF_Flush},    {31'd0, rdy && !taken});
            if (!rdy)        chk("instr_stall", instruction, 32'd0);
            else if (!taken) chk("instr_fetch", instruction, rd);
            if (taken)                m_pc = target;
            else if (rdy && pcw)      m_pc = p4;
            else if (rdy) begin
                m_parked = 1'b1;
                m_word   = rd;
            end
        end else begin
            chk("imem_req_hold",    {31'd0, imem_req},    32'd0);
            chk("fetch_stall_hold", {31'd0, fetch_stall}, 32'd0);
            chk("IF_Flush_hold",    {31'd0, IF_Flush},    {31'd0, !taken});
            if (!taken) chk("instr_hold", instruction, m_word);
            if (taken) begin
                m_pc     = target;
                m_parked = 1'b0;
            end else if (pcw) begin
                m_pc     = p4;
                m_parked = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse mid-cycle with hostile inputs; returns at a negedge.
    task automatic do_reset();
        PCWrite    = 1'b1;
        PCSrc      = 3'd3;
        jr_target  = 32'h0000_0202;
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_imem_req",    {31'd0, imem_req},    32'd0);
        chk("rst_instruction", instruction,          32'd0);
        chk("rst_IF_Flush",    {31'd0, IF_Flush},    32'd0);
        chk("rst_fetch_stall", {31'd0, fetch_stall}, 32'd0);
        chk("rst_addr_err",    {31'd0, addr_err},    32'd0);
        chk("rst_imem_addr",   imem_addr,            RV);
        m_pc     = RV;
        m_parked = 1'b0;
        m_word   = 32'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] rd;
        logic [31:0] bt;
        logic [31:0] jrt;
        logic [25:0] jt;
        logic [2:0]  src;
        logic        pcw;
        logic        rdy;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        PCWrite = 1'b0; PCSrc = 3'd0; branch_target = 32'd0; jump_target = 26'd0;
        jr_target = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
        m_pc = RV; m_parked = 1'b0; m_word = 32'd0;
        @(negedge clk);
        do_reset();

        // Back-to-back fetch 0,4,8,C
        for (int i = 0; i < 4; i++) step(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 1'b1, 32'h1000_0000 + 32'(i));
        // Three wait cycles at 0x10, then delivery
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 1'b0, 32'hBAD0_0000);
        step(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 1'b1, 32'h1111_0010);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 1'b1, 32'h2222_0000 + 32'(i));
        // Stall capture at 0x20, held for two cycles, then release
        step(1'b0, 3'd0, 32'd0, 26'd0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 3'd0, 32'd0, 26'd0, 32'd0, 1'b1, 32'h0BAD_0BAD);
        step(1'b0, 3'd0, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0BAD_0BAD);
        step(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 1'b0, 32'd0);
        chk("addr_after_hold", imem_addr, 32'h0000_0024);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 1'b1, 32'h3333_0000 + 32'(i));
        // Branch at 0x30, jump at 0x100, misaligned jr
        step(1'b1, 3'd1, 32'h0000_0100, 26'd0, 32'd0, 1'b1, 32'h4444_0030);
        chk("addr_branch", imem_addr, 32'h0000_0100);
        step(1'b1, 3'd2, 32'd0, 26'h40, 32'd0, 1'b1, 32'h4444_0100);
        chk("addr_jump", imem_addr, 32'h0000_0100);
        step(1'b1, 3'd3, 32'd0, 26'd0, 32'h0000_0202, 1'b1, 32'h4444_0101);
        chk("addr_jr_exc", imem_addr, EV);
        step(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 1'b1, 32'h5555_0000);
        // Enter HOLD, interrupt with PCWrite=0 drops the buffer
        step(1'b0, 3'd0, 32'd0, 26'd0, 32'd0, 1'b1, 32'h6666_0000);
        step(1'b0, 3'd4, 32'd0, 26'd0, 32'd0, 1'b0, 32'd0);
        chk("addr_int", imem_addr, IV);
        step(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 1'b1, 32'h7777_0000);
        // Reset while in HOLD, then while a request is pending
        step(1'b0, 3'd0, 32'd0, 26'd0, 32'd0, 1'b1, 32'h8888_0000);
        do_reset();
        step(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 1'b0, 32'd0);
        do_reset();
        step(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 1'b1, 32'h9999_0000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                r   = $urandom_range(0, 15);
                src = (r < 32'd9) ? 3'd0 : r[2:0] + 3'd0;
                if (r >= 32'd9) src = 3'(r - 32'd8);
                pcw = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 3) != 0);
                rd  = $urandom;
                bt  = $urandom;
                bt[1:0] = 2'b00;
                r   = $urandom;
                jt  = r[25:0];
                jrt = $urandom;
                if ($urandom_range(0, 1) == 0) jrt[1:0] = 2'b00;
                step(pcw, src, bt, jt, jrt, rdy, rd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
